// File: rtl/nf_alu_dec_stage.sv
//------------------------------------------------------------------------------
// nf_alu_dec_stage
//
// Registered RV32I decode stage feeding the nf_alu execute unit. Decodes LUI,
// ADD, ADDI, SUB, SLLI, OR and ORI into ALU operation / operand-select fields
// and flags every other encoding as illegal (illegal entries still flow
// through the handshake). A 2-entry skid buffer (main + skid register) keeps
// full throughput on valid/ready handshakes at both sides.
//
// Ports:
//   clk        in   1  clock, rising edge
//   resetn     in   1  asynchronous active-low reset
//   instr_i    in  32  instruction word
//   instr_vld  in   1  instr_i valid
//   instr_rdy  out  1  stage can accept (registered; 1 while skid is empty)
//   flush      in   1  synchronous discard of all held entries
//   dec_vld    out  1  decoded entry valid (main register occupied)
//   dec_rdy    in   1  downstream accepts the entry
//   ALU_Code   out  3  LUI=000 ADD=001 SLL=010 OR=011 SUB=100
//   shamt      out  5  shift amount
//   ra1, ra2   out  5  register-file read addresses
//   wa3        out  5  register-file write address
//   ext_data   out 32  immediate for srcB
//   srcB_sel   out  1  1: srcB = ext_data, 0: srcB = rf read 2
//   we_rf      out  1  register-file write enable
//   illegal    out  1  unsupported encoding
//------------------------------------------------------------------------------
module nf_alu_dec_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] instr_i,
    input  logic        instr_vld,
    output logic        instr_rdy,
    input  logic        flush,
    output logic        dec_vld,
    input  logic        dec_rdy,
    output logic [2:0]  ALU_Code,
    output logic [4:0]  shamt,
    output logic [4:0]  ra1,
    output logic [4:0]  ra2,
    output logic [4:0]  wa3,
    output logic [31:0] ext_data,
    output logic        srcB_sel,
    output logic        we_rf,
    output logic        illegal
);

    typedef enum logic [2:0] {
        ALU_LUI = 3'b000,
        ALU_ADD = 3'b001,
        ALU_SLL = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SUB = 3'b100
    } alu_e;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opc_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]  alu_code;
        logic [4:0]  shamt;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  wa3;
        logic [31:0] ext_data;
        logic        srcb_sel;
        logic        we_rf;
        logic        illegal;
    } dec_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic        w_legal;
    dec_t        w_dec;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_funct7 = instr_i[31:25];
    assign w_imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};

    always_comb begin
        w_dec          = '0;
        w_legal        = 1'b0;
        w_dec.alu_code = ALU_ADD;
        w_dec.ra1      = instr_i[19:15];
        w_dec.ra2      = instr_i[24:20];
        w_dec.wa3      = instr_i[11:7];
        w_dec.shamt    = instr_i[24:20];

        unique case (w_opcode)
            OPC_LUI: begin
                w_legal        = 1'b1;
                w_dec.alu_code = ALU_LUI;
                // Upper immediate is passed unshifted; nf_alu applies the <<12.
                w_dec.ext_data = {12'b0, instr_i[31:12]};
                w_dec.ra1      = '0;
                w_dec.srcb_sel = 1'b1;
                w_dec.we_rf    = 1'b1;
            end
            OPC_OP_IMM: begin
                w_dec.srcb_sel = 1'b1;
                w_dec.we_rf    = 1'b1;
                unique case (w_funct3)
                    3'b000: begin
                        w_legal        = 1'b1;
                        w_dec.alu_code = ALU_ADD;
                        w_dec.ext_data = w_imm_i;
                    end
                    3'b110: begin
                        w_legal        = 1'b1;
                        w_dec.alu_code = ALU_OR;
                        w_dec.ext_data = w_imm_i;
                    end
                    3'b001: begin
                        if (w_funct7 == 7'b0000000) begin
                            w_legal        = 1'b1;
                            w_dec.alu_code = ALU_SLL;
                        end
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_OP: begin
                w_dec.srcb_sel = 1'b0;
                w_dec.we_rf    = 1'b1;
                if (w_funct3 == 3'b000 && w_funct7 == 7'b0000000) begin
                    w_legal        = 1'b1;
                    w_dec.alu_code = ALU_ADD;
                end else if (w_funct3 == 3'b000 && w_funct7 == 7'b0100000) begin
                    w_legal        = 1'b1;
                    w_dec.alu_code = ALU_SUB;
                end else if (w_funct3 == 3'b110 && w_funct7 == 7'b0000000) begin
                    w_legal        = 1'b1;
                    w_dec.alu_code = ALU_OR;
                end
            end
            default: w_legal = 1'b0;
        endcase

        // Illegal encodings become a harmless no-write ADD; register fields
        // are kept so the entry still carries its raw operand addresses.
        if (!w_legal) begin
            w_dec.illegal  = 1'b1;
            w_dec.we_rf    = 1'b0;
            w_dec.alu_code = ALU_ADD;
            w_dec.ext_data = '0;
            w_dec.srcb_sel = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy FSM
    // ------------------------------------------------------------------
    state_e r_state;
    state_e w_state_nxt;
    logic   r_instr_rdy;
    logic   w_accept;
    logic   w_drain;
    logic   w_load_main;
    logic   w_load_skid;
    logic   w_skid_to_main;
    dec_t   r_main;
    dec_t   r_skid;

    assign w_accept = instr_vld & r_instr_rdy;
    assign w_drain  = (r_state != ST_EMPTY) & dec_rdy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_EMPTY;
            r_instr_rdy <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_instr_rdy <= (w_state_nxt != ST_FULL);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;

        unique case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_MAIN;
                    w_load_main = 1'b1;
                end
            end
            ST_MAIN: begin
                if (w_accept && w_drain) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // instr_rdy is low here, so no accept can coincide.
                if (w_drain) begin
                    w_state_nxt    = ST_MAIN;
                    w_skid_to_main = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase

        if (flush) begin
            w_state_nxt    = ST_EMPTY;
            w_load_main    = 1'b0;
            w_load_skid    = 1'b0;
            w_skid_to_main = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Entry registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= w_dec;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    assign instr_rdy = r_instr_rdy;
    assign dec_vld   = (r_state != ST_EMPTY);
    assign ALU_Code  = r_main.alu_code;
    assign shamt     = r_main.shamt;
    assign ra1       = r_main.ra1;
    assign ra2       = r_main.ra2;
    assign wa3       = r_main.wa3;
    assign ext_data  = r_main.ext_data;
    assign srcB_sel  = r_main.srcb_sel;
    assign we_rf     = r_main.we_rf;
    assign illegal   = r_main.illegal;

endmodule
